aes_job_scheduler: RTL and testbench
====================================

AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one AES-128 core (range 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit in cycles from core start to core done.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester job offer.
REQ-006 SHALL have port req_ready, output, NUM_REQ, per-requester job accept.
REQ-007 SHALL have port req_text, input, NUM_REQ x 128 (text_t), per-requester plaintext.
REQ-008 SHALL have port req_key, input, NUM_REQ x 128 (key_t), per-requester key.
REQ-009 SHALL have port core_start, output, 1, start pulse to AES core.
REQ-010 SHALL have port core_text, output, 128 (text_t), plaintext to core, held stable while job is active.
REQ-011 SHALL have port core_key, output, 128 (key_t), key to core, held stable while job is active.
REQ-012 SHALL have port core_done, input, 1, core completion flag.
REQ-013 SHALL have port core_result, input, 128 (text_t), core ciphertext, valid when core_done=1.
REQ-014 SHALL have port rsp_valid, output, 1, response available.
REQ-015 SHALL have port rsp_ready, input, 1, response consumed.
REQ-016 SHALL have port rsp_id, output, clog2(NUM_REQ), index of the requester the response belongs to.
REQ-017 SHALL have port rsp_text, output, 128 (text_t), ciphertext.
REQ-018 SHALL have port rsp_error, output, 1, job aborted by watchdog; rsp_text is all-zero when set.

Function
REQ-019 SHALL implement FSM IDLE -> START -> BUSY -> RESP -> IDLE.
REQ-020 IDLE: SHALL perform round-robin arbitration over req_valid; winner gets a one-cycle req_ready pulse; text, key and id latch on that edge; next state START.
REQ-021 SHALL assert req_ready only in IDLE, for at most one requester per cycle, and never while rsp_valid=1.
REQ-022 Round-robin SHALL search from pointer upward with wrap-around; after a grant, pointer = winner+1 mod NUM_REQ; pointer holds when there is no grant.
REQ-023 START: SHALL drive core_start=1 for exactly one cycle; next state BUSY.
REQ-024 BUSY: on core_done=1, SHALL capture core_result into rsp_text with rsp_error=0 and go to RESP.
REQ-025 RESP: SHALL hold rsp_valid=1 with rsp_id, rsp_text and rsp_error stable until rsp_ready=1; that cycle returns to IDLE.
REQ-026 Minimum latency SHALL be: grant edge, core_start the next cycle, rsp_valid the cycle after core_done.
REQ-027 SHALL ignore core_done in IDLE, START and RESP.
REQ-028 SHALL not accept back-to-back jobs: each grant completes its response handshake before the next arbitration.

Reset
REQ-029 While reset=1, SHALL set state IDLE, pointer 0, req_ready 0, core_start 0, rsp_valid 0, rsp_error 0, rsp_id 0, rsp_text 0, core_text 0, core_key 0, watchdog 0.
REQ-030 Reset during START, BUSY or RESP SHALL abandon the job silently, with no response; a later core_done is ignored under REQ-027.

Configuration
REQ-031 With AES_SCHED_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle; when it reaches TIMEOUT_CYCLES without core_done, the block SHALL go to RESP with rsp_error=1 and rsp_text=0.
REQ-032 If core_done and timeout occur in the same cycle, core_done SHALL win, giving rsp_error=0.
REQ-033 Without AES_SCHED_TIMEOUT_EN, there SHALL be no counter, BUSY SHALL wait indefinitely, and rsp_error SHALL be tied to 0.

Structure
REQ-034 text_t and key_t SHALL come from DesignPkg; DesignPkg SHALL also gain sched_state_t (enum of the four states) and the SCHED_TIMEOUT_DEFAULT constant.
REQ-035 Round-robin selection SHALL live in a sub-module rr_arbiter (inputs req and pointer; outputs one-hot grant and index).

Verification
REQ-036 After reset, req_valid=4'b0001 with text 0x00112233445566778899aabbccddeeff and key 0x000102030405060708090a0b0c0d0e0f -> req_ready[0] pulse, then a one-cycle core_start, then rsp_id=0 and rsp_text=0x69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-037 req_valid=4'b1111 held throughout -> grants in order 0,1,2,3,0.
REQ-038 Pointer=2 with req_valid=4'b0011 -> grant 0 via wrap-around; pointer becomes 1.
REQ-039 rsp_ready held 0 for 10 cycles -> rsp_valid, rsp_id and rsp_text stable all 10 cycles; req_ready stays 0 throughout.
REQ-040 AES_SCHED_TIMEOUT_EN defined and core_done never asserted -> rsp_error=1 and rsp_text=0 exactly 64 BUSY cycles after core_start; with core_done forced in cycle 64 instead -> rsp_error=0.
REQ-041 reset=1 for one cycle during BUSY, then core_done=1 -> no rsp_valid; state IDLE; next request serviced normally.

Source files
------------

// File: rtl/DesignPkg.sv
// Shared types and constants for the AES job scheduler slice.
package DesignPkg;

    typedef logic [127:0] text_t;
    typedef logic [127:0] key_t;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_START = 2'd1,
        SCHED_BUSY  = 2'd2,
        SCHED_RESP  = 2'd3
    } sched_state_t;

    localparam int    SCHED_TIMEOUT_DEFAULT = 64;
    localparam text_t TEXT_ZERO             = 128'h0;
    localparam key_t  KEY_ZERO              = 128'h0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first asserted request at or above pointer, with wrap-around.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    logic [IW-1:0] idx_s;
    logic          found_s;
    logic          hit_s;

    // Walk the ring once starting at the pointer; the first hit wins
    always_comb begin
        grant   = {N{1'b0}};
        index   = {IW{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = pointer;
        for (int i = 0; i < N; i++) begin
            hit_s        = !found_s && req[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            index        = hit_s ? idx_s : index;
            found_s      = found_s | hit_s;
            idx_s        = (idx_s == IW'(N - 1)) ? {IW{1'b0}} : idx_s + IW'(1);
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES-128 core among NUM_REQ requesters, one job at a time.
// Optional watchdog abort enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_job_scheduler
    import DesignPkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = SCHED_TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  text_t [NUM_REQ-1:0]        req_text,
    input  key_t  [NUM_REQ-1:0]        req_key,
    output logic                       core_start,
    output text_t                      core_text,
    output key_t                       core_key,
    input  logic                       core_done,
    input  text_t                      core_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output text_t                      rsp_text,
    output logic                       rsp_error
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in the range 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    sched_state_t       state_r;
    logic [ID_W-1:0]    ptr_r;
    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic               grant_any_s;
    logic               core_start_r;
    text_t              core_text_r;
    key_t               core_key_r;
    logic               rsp_valid_r;
    logic [ID_W-1:0]    rsp_id_r;
    text_t              rsp_text_r;

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_r;
    logic            rsp_error_r;
`endif

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req     (req_valid),
        .pointer (ptr_r),
        .grant   (grant_s),
        .index   (grant_idx_s)
    );

    assign grant_any_s = |grant_s;

    // Accept is combinational so the handshake edge is also the latch edge
    always_comb begin
        if (!reset && state_r == SCHED_IDLE && !rsp_valid_r) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Job sequencing: arbitrate, launch core, wait for result, hand it back
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= SCHED_IDLE;
            ptr_r        <= {ID_W{1'b0}};
            core_start_r <= 1'b0;
            core_text_r  <= TEXT_ZERO;
            core_key_r   <= KEY_ZERO;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= {ID_W{1'b0}};
            rsp_text_r   <= TEXT_ZERO;
`ifdef AES_SCHED_TIMEOUT_EN
            wd_cnt_r     <= {WD_W{1'b0}};
            rsp_error_r  <= 1'b0;
`endif
        end else begin
            core_start_r <= 1'b0;
            case (state_r)
                SCHED_IDLE: begin
                    if (grant_any_s && !rsp_valid_r) begin
                        core_text_r  <= req_text[grant_idx_s];
                        core_key_r   <= req_key[grant_idx_s];
                        rsp_id_r     <= grant_idx_s;
                        ptr_r        <= (grant_idx_s == ID_W'(NUM_REQ - 1)) ?
                                        {ID_W{1'b0}} : grant_idx_s + ID_W'(1);
                        core_start_r <= 1'b1;
                        state_r      <= SCHED_START;
                    end else begin
                        state_r <= SCHED_IDLE;
                    end
                end
                SCHED_START: begin
`ifdef AES_SCHED_TIMEOUT_EN
                    wd_cnt_r <= {WD_W{1'b0}};
`endif
                    state_r <= SCHED_BUSY;
                end
                SCHED_BUSY: begin
                    // A completion in the final watchdog cycle still counts as success
                    if (core_done) begin
                        rsp_text_r  <= core_result;
                        rsp_valid_r <= 1'b1;
                        state_r     <= SCHED_RESP;
`ifdef AES_SCHED_TIMEOUT_EN
                        rsp_error_r <= 1'b0;
                    end else if (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_text_r  <= TEXT_ZERO;
                        rsp_error_r <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state_r     <= SCHED_RESP;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_W'(1);
                        state_r  <= SCHED_BUSY;
`else
                    end else begin
                        state_r <= SCHED_BUSY;
`endif
                    end
                end
                SCHED_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= SCHED_IDLE;
                    end else begin
                        state_r <= SCHED_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= SCHED_IDLE;
                end
            endcase
        end
    end

    assign core_start = core_start_r;
    assign core_text  = core_text_r;
    assign core_key   = core_key_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_text   = rsp_text_r;
`ifdef AES_SCHED_TIMEOUT_EN
    assign rsp_error  = rsp_error_r;
`else
    assign rsp_error  = 1'b0;
`endif

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler; the core is modelled by driving core_done by hand.
module tb_aes_job_scheduler;
    import DesignPkg::*;

    localparam int N = 4;
    localparam text_t PT  = 128'h00112233445566778899aabbccddeeff;
    localparam key_t  KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam text_t CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    text_t [N-1:0]  req_text;
    key_t  [N-1:0]  req_key;
    logic           core_start;
    text_t          core_text;
    key_t           core_key;
    logic           core_done;
    text_t          core_result;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    text_t          rsp_text;
    logic           rsp_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_job_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_text    (req_text),
        .req_key     (req_key),
        .core_start  (core_start),
        .core_text   (core_text),
        .core_key    (core_key),
        .core_done   (core_done),
        .core_result (core_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_text    (rsp_text),
        .rsp_error   (rsp_error)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 4'b0000;
        core_done = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge with inputs set; returns the first non-zero req_ready
    task automatic wait_grant(output logic [N-1:0] g, output bit ok);
        ok = 1'b0;
        g = 4'b0000;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (req_ready != 4'b0000) begin
                ok = 1'b1;
                g = req_ready;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    // Runs a granted job to completion; ends at the negedge of the next IDLE cycle
    task automatic drive_job(input text_t res);
        @(negedge clk);
        @(negedge clk);
        core_done = 1'b1;
        core_result = res;
        @(negedge clk);
        core_done = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b1111;
        core_done = 1'b1;
        core_result = CT;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_text[i] = PT ^ text_t'(i);
            req_key[i] = KEY ^ key_t'(i);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if ({core_start, rsp_valid, rsp_error, rsp_id} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl: start=%b valid=%b err=%b id=%0d expected all 0",
                     core_start, rsp_valid, rsp_error, rsp_id);
        end
        checks++;
        if (rsp_text !== TEXT_ZERO || core_text !== TEXT_ZERO || core_key !== KEY_ZERO) begin
            errors++;
            $display("FAIL reset_data: rsp_text=%h core_text=%h core_key=%h expected 0",
                     rsp_text, core_text, core_key);
        end
        @(negedge clk);
        reset = 1'b0;
        req_valid = 4'b0000;
        core_done = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b start=%b expected 0 0", rsp_valid, core_start);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_text[0] = PT;
        req_key[0] = KEY;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++;
        if (core_start !== 1'b1 || core_text !== PT || core_key !== KEY) begin
            errors++;
            $display("FAIL single_start: start=%b text=%h key=%h expected 1 %h %h",
                     core_start, core_text, core_key, PT, KEY);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_ready_start: req_ready=%b expected 0000", req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (core_start !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: start=%b valid=%b expected 0 0", core_start, rsp_valid);
        end
        core_done = 1'b1;
        core_result = CT;
        @(negedge clk);
        core_done = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_text !== CT || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL single_resp: valid=%b id=%0d text=%h err=%b expected 1 0 %h 0",
                     rsp_valid, rsp_id, rsp_text, rsp_error, CT);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [5];
        logic [N-1:0] g;
        bit ok;
        exp_g[0] = 4'b0001;
        exp_g[1] = 4'b0010;
        exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000;
        exp_g[4] = 4'b0001;
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, ok);
            checks++;
            if (!ok || g !== exp_g[k]) begin
                errors++;
                $display("FAIL rr_order[%0d]: req_ready=%b expected %b", k, g, exp_g[k]);
            end
            drive_job(CT ^ text_t'(k));
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_wrap();
        logic [N-1:0] g;
        bit ok;
        do_reset();
        req_valid = 4'b0010;
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_setup: req_ready=%b expected 0010", g);
        end
        drive_job(CT);
        req_valid = 4'b0011;
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_grant: req_ready=%b expected 0001", g);
        end
        drive_job(CT);
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_pointer: req_ready=%b expected 0010", g);
        end
        drive_job(CT);
        req_valid = 4'b0000;
    endtask

    task automatic test_hold();
        logic [N-1:0] g;
        bit ok;
        text_t res;
        res = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        req_valid = 4'b0100;
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b0100) begin
            errors++;
            $display("FAIL hold_grant: req_ready=%b expected 0100", g);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        @(negedge clk);
        core_done = 1'b1;
        core_result = res;
        @(negedge clk);
        core_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_text !== res || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL hold_cycle[%0d]: valid=%b id=%0d text=%h ready=%b expected 1 2 %h 0000",
                         c, rsp_valid, rsp_id, rsp_text, req_ready, res);
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid_job();
        logic [N-1:0] g;
        bit ok;
        req_valid = 4'b1000;
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_grant: req_ready=%b expected 1000", g);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        core_done = 1'b1;
        core_result = CT;
        @(negedge clk);
        core_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || core_start !== 1'b0) begin
                errors++;
                $display("FAIL midrst_silent[%0d]: valid=%b start=%b expected 0 0", c, rsp_valid, core_start);
            end
            @(negedge clk);
        end
        req_text[0] = PT;
        req_key[0] = KEY;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_idle: req_ready=%b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++;
        if (core_start !== 1'b1 || core_text !== PT) begin
            errors++;
            $display("FAIL midrst_restart: start=%b text=%h expected 1 %h", core_start, core_text, PT);
        end
        @(negedge clk);
        core_done = 1'b1;
        core_result = CT;
        @(negedge clk);
        core_done = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_text !== CT) begin
            errors++;
            $display("FAIL midrst_resp: valid=%b id=%0d text=%h expected 1 0 %h", rsp_valid, rsp_id, rsp_text, CT);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_watchdog();
        logic [N-1:0] g;
        bit ok;
        bit early;
        req_valid = 4'b0001;
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b0001) begin
            errors++;
            $display("FAIL wd_grant: req_ready=%b expected 0001", g);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        early = 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            #1;
            early = early | rsp_valid;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL wd_early: rsp_valid seen=%b expected 0 within 64 busy cycles", early);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_text !== TEXT_ZERO) begin
            errors++;
            $display("FAIL wd_abort: valid=%b err=%b text=%h expected 1 1 0", rsp_valid, rsp_error, rsp_text);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        wait_grant(g, ok);
        @(negedge clk);
        req_valid = 4'b0000;
        for (int c = 1; c <= 63; c++) begin
            @(negedge clk);
        end
        @(negedge clk);
        core_done = 1'b1;
        core_result = CT;
        @(negedge clk);
        core_done = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_text !== CT) begin
            errors++;
            $display("FAIL wd_done_wins: valid=%b err=%b text=%h expected 1 0 %h", rsp_valid, rsp_error, rsp_text, CT);
        end
`else
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            #1;
            early = early | rsp_valid | rsp_error;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL nowd_wait: response seen=%b expected 0 after 100 busy cycles", early);
        end
        core_done = 1'b1;
        core_result = CT;
        @(negedge clk);
        core_done = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_text !== CT) begin
            errors++;
            $display("FAIL nowd_done: valid=%b err=%b text=%h expected 1 0 %h", rsp_valid, rsp_error, rsp_text, CT);
        end
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_hold();
        test_reset_mid_job();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
